// File: rtl/fir_out_buffer.sv
// Output buffer behind the FIR core: a small FIFO between sm_* and the downstream
// AXI-Stream, with frame-length tracking, a regenerated tlast and sticky tlast errors.
module fir_out_buffer #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8
) (
  input  logic                      axis_clk,
  input  logic                      axis_rst_n,
  input  logic                      s_tvalid,
  input  logic [pDATA_WIDTH-1:0]    s_tdata,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic                      m_tvalid,
  output logic [pDATA_WIDTH-1:0]    m_tdata,
  output logic                      m_tlast,
  input  logic                      m_tready,
  input  logic [31:0]               cfg_len,
  input  logic                      cfg_start,
  output logic                      busy,
  output logic                      done,
  output logic                      err_early_last,
  output logic                      err_missing_last,
  output logic [$clog2(pDEPTH):0]   level
);
  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [31:0]      in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, len_q, len_d;
  logic             err_early_q, err_early_d, err_miss_q, err_miss_d;
  logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];

  logic        push, pop;
  logic [31:0] len_m1;

  assign len_m1   = len_q - 32'd1;
  assign s_tready = (state_q == RUN) && (level_q < LW'(pDEPTH));
  assign m_tvalid = (level_q != '0);
  // Gate the head word so the output reads 0 while empty (storage is never cleared).
  assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign m_tlast  = m_tvalid && (out_cnt_q == len_m1);
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign err_early_last   = err_early_q;
  assign err_missing_last = err_miss_q;
  assign level            = level_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    len_d       = len_q;
    err_early_d = err_early_q;
    err_miss_d  = err_miss_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      in_cnt_d = in_cnt_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      out_cnt_d = out_cnt_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE, DONE: begin
        if (cfg_start) begin
          len_d       = cfg_len;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          err_early_d = 1'b0;
          err_miss_d  = 1'b0;
          state_d     = (cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (push) begin
          if (in_cnt_q == len_m1) begin
            state_d = DRAIN;
            if (!s_tlast) err_miss_d = 1'b1;
          end else if (s_tlast && (in_cnt_q < len_m1)) begin
            err_early_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && (out_cnt_q == len_m1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      len_q       <= '0;
      err_early_q <= 1'b0;
      err_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      len_q       <= len_d;
      err_early_q <= err_early_d;
      err_miss_q  <= err_miss_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata;
  end
endmodule
